// File: rtl/time_rollover_detect_pkg.sv
// time_rollover_detect_pkg: shared constants and lock-state encoding (ALARM_EN selects the alarm option elsewhere)
package time_rollover_detect_pkg;
  localparam int DIGIT_W = 4;
  // Terminal values are held BCD-encoded so they compare directly against digit pairs
  localparam logic [7:0] SEC_MIN_MAX  = 8'h59;
  localparam logic [7:0] H24_MAX      = 8'h23;
  localparam logic [7:0] H12_MAX      = 8'h12;
  localparam logic [7:0] H12_MERIDIAN = 8'h11;
  typedef enum logic {IDLE, LOCK} lock_state_e;
endpackage

// File: rtl/time_rollover_detect_if.sv
// time_rollover_detect_if: time word in, wrap/meridian/error flags out; ALARM_EN adds the alarm signals
interface time_rollover_detect_if #(parameter int NUM_DIGITS = 6);
  import time_rollover_detect_pkg::*;
  logic                          tick_i;
  logic                          mode_12h_i;
  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_i;
  logic                          wrap_o;
  logic                          term_o;
  logic                          pm_o;
  logic                          bcd_err_o;
`ifdef ALARM_EN
  logic                          alarm_set_i;
  logic [DIGIT_W*NUM_DIGITS-1:0] alarm_bcd_i;
  logic                          alarm_pm_i;
  logic                          alarm_on_i;
  logic                          alarm_o;
  modport master (output tick_i, mode_12h_i, bcd_i, alarm_set_i, alarm_bcd_i, alarm_pm_i, alarm_on_i,
                  input wrap_o, term_o, pm_o, bcd_err_o, alarm_o);
  modport slave (input tick_i, mode_12h_i, bcd_i, alarm_set_i, alarm_bcd_i, alarm_pm_i, alarm_on_i,
                 output wrap_o, term_o, pm_o, bcd_err_o, alarm_o);
`else
  modport master (output tick_i, mode_12h_i, bcd_i, input wrap_o, term_o, pm_o, bcd_err_o);
  modport slave (input tick_i, mode_12h_i, bcd_i, output wrap_o, term_o, pm_o, bcd_err_o);
`endif
endinterface

// File: rtl/time_rollover_detect_event_lock.sv
// time_rollover_detect_event_lock: fires once on a ticked match, then locks until the match drops
module time_rollover_detect_event_lock
  import time_rollover_detect_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic match_i,
  input  logic tick_i,
  output logic fire_o
);
  lock_state_e state_q;
  assign fire_o = (state_q == IDLE) & tick_i & match_i;
  // Enter LOCK on the firing cycle; leave only once the watched value no longer matches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= fire_o ? LOCK : (match_i ? state_q : IDLE);
endmodule

// File: rtl/time_rollover_detect.sv
// time_rollover_detect: two-stage BCD terminal-count detector with one-shot WRAP and PM tracking (ALARM_EN adds alarm)
module time_rollover_detect
  import time_rollover_detect_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  time_rollover_detect_if.slave tr
);
  localparam int W = DIGIT_W*NUM_DIGITS;
  logic [W-1:0] bcd_q;
  logic         tick_q, mode_q;
  logic [7:0]   top;
  logic         low_ok, err, term_hit, mer_hit, wrap_fire, mer_fire;
  logic         wrap_q, term_q, pm_q, err_q;
  assign top = bcd_q[W-1 -: 8];
  // Lower pairs must read 59, every digit must be decimal and each tens digit in range
  always_comb begin
    low_ok = 1'b1;
    err = top[7:4] > (mode_q ? 4'd1 : 4'd2);
    for (int p = 0; p < NUM_DIGITS/2-1; p++) begin
      low_ok &= bcd_q[8*p +: 8] == SEC_MIN_MAX;
      err |= bcd_q[8*p+4 +: 4] > 4'd5;
    end
    for (int k = 0; k < NUM_DIGITS; k++) err |= bcd_q[4*k +: 4] > 4'd9;
    term_hit = ~err & low_ok & (top == (mode_q ? H12_MAX : H24_MAX));
    mer_hit = ~err & mode_q & low_ok & (top == H12_MERIDIAN);
  end
  time_rollover_detect_event_lock u_wrap (.clk(clk), .rst_n(rst_n), .match_i(term_hit), .tick_i(tick_q), .fire_o(wrap_fire));
  time_rollover_detect_event_lock u_mer (.clk(clk), .rst_n(rst_n), .match_i(mer_hit), .tick_i(tick_q), .fire_o(mer_fire));
`ifdef ALARM_EN
  logic [W-1:0] alm_bcd_q;
  logic         alm_pm_q, on_q, alm_hit, alm_fire, alarm_q;
  assign alm_hit = on_q & ~err & (bcd_q == alm_bcd_q) & (~mode_q | (pm_q == alm_pm_q));
  time_rollover_detect_event_lock u_alm (.clk(clk), .rst_n(rst_n), .match_i(alm_hit), .tick_i(tick_q), .fire_o(alm_fire));
  // Alarm setting loads directly; a match in the load cycle still sees the previous setting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alm_bcd_q <= '0;
      alm_pm_q <= 1'b0;
      on_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      if (tr.alarm_set_i) begin
        alm_bcd_q <= tr.alarm_bcd_i;
        alm_pm_q <= tr.alarm_pm_i;
      end
      on_q <= tr.alarm_on_i;
      alarm_q <= alm_fire;
    end
  assign tr.alarm_o = alarm_q;
`endif
  // Stage 1 samples the time word alongside its tick and mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcd_q <= '0;
      tick_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      bcd_q <= tr.bcd_i;
      tick_q <= tr.tick_i;
      mode_q <= tr.mode_12h_i;
    end
  // Stage 2 registers the flags; PM toggles at 11:59[:59] and is held clear in 24 h mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrap_q <= 1'b0;
      term_q <= 1'b0;
      pm_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wrap_q <= wrap_fire;
      term_q <= term_hit;
      pm_q <= mode_q & (pm_q ^ mer_fire);
      err_q <= err;
    end
  assign tr.wrap_o = wrap_q;
  assign tr.term_o = term_q;
  assign tr.pm_o = pm_q;
  assign tr.bcd_err_o = err_q;
endmodule

// File: doc/time_rollover_detect.md
# time_rollover_detect

Parametrised terminal-count detector for the watch's BCD time chain. It registers the packed BCD time and detects the rollover instant for 24 h or 12 h mode, generating one-cycle WRAP pulses that reset the counter chain. It also maintains the AM/PM flag and flags invalid digits. It sits between the BCD counter chain and the counter reset/display logic, with one-pulse-per-event locking so a stalled counter never produces repeated wraps.

## Interface
- NUM_DIGITS, 6, BCD digits in the time word; legal values 4 (HH:MM) or 6 (HH:MM:SS); digit 0 is the least significant.
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- TICK  in  1  one-cycle strobe; the counter advances on the CLK edge ending this cycle.
- BCD  in  4*NUM_DIGITS  packed current time; digit k at bits [4k+3:4k].
- MODE_12H  in  1  0 = 24 h, 1 = 12 h; sampled with BCD.
- WRAP  out  1  one-cycle pulse; the counter must load its wrap value.
- TERM  out  1  registered level: the sampled BCD equals the current terminal value.
- PM  out  1  meridian flag; meaningful in 12 h mode, forced 0 in 24 h mode.
- BCD_ERR  out  1  registered level: some sampled digit > 9, or a tens digit out of range.

## Operation
- Stage 1 registers BCD, TICK and MODE_12H as bcd_q, tick_q and mode_q.
- Stage 2 compares bcd_q.
  - Lower pairs must equal 59.
  - Top pair terminal is 23 (24 h) or 12 (12 h).
  - Meridian point is 11 (12 h only).
- Event FSM states: IDLE, LOCK.
  - IDLE → LOCK when tick_q & term_hit; WRAP pulses for one cycle.
  - LOCK → IDLE when bcd_q ≠ terminal value.
  - In LOCK, further tick_q with an unchanged terminal value produces no pulse.
- Meridian FSM: PM toggles on tick_q while mode_q=1 and bcd_q equals the meridian point with lower pairs at 59 (11:59[:59]). The same LOCK rule applies.
- Mode change: mode_q=0 clears PM on the next cycle. A mode change mid-LOCK returns the FSM to IDLE once bcd_q no longer matches the new terminal value.
- BCD_ERR suppresses WRAP, PM toggle and ALARM for that cycle. TERM stays 0 while BCD_ERR=1.
- Reset: WRAP=0, TERM=0, PM=0, BCD_ERR=0, FSM=IDLE, all pipeline registers 0.

## Timing
- BCD/TICK sampled at edge n, registered at n+1; WRAP, TERM and BCD_ERR are valid after edge n+2. Fixed latency 2 cycles, no bubbles.
- WRAP width is exactly one cycle.
- Back-to-back TICKs are legal.
- RST_N assertion clears all state immediately, mid-pulse included. The first sample is taken on the first edge after deassertion.

## Configuration
- ALARM_EN defined adds:
  - ALARM_SET (in, 1): loads the alarm register.
  - ALARM_BCD (in, 4*NUM_DIGITS): alarm time.
  - ALARM_PM (in, 1): alarm meridian.
  - ALARM_ON (in, 1): enables the alarm.
  - ALARM (out, 1): one-cycle pulse when ALARM_ON & tick_q & bcd_q == alarm register (and PM == ALARM_PM in 12 h mode).
  - The alarm has its own LOCK state.
  - The alarm register resets to 0 and loads one cycle after ALARM_SET.
  - ALARM_SET and a match in the same cycle compare against the old value.
- ALARM_EN undefined: none of these ports or registers exist, and WRAP/PM behaviour is unchanged.

## Structure
- Shared package holds:
  - BCD digit width 4.
  - Constants SEC_MIN_MAX=59, H24_MAX=23, H12_MAX=12, H12_MERIDIAN=11.
  - Event FSM state encoding IDLE/LOCK.
- One sub-module, event_lock: generic match+tick → one-shot pulse with LOCK-until-mismatch. It is instantiated for WRAP, the PM toggle and (under ALARM_EN) ALARM.

## Test plan
- 24 h, NUM_DIGITS=6: BCD=23:59:59 with TICK → WRAP=1 exactly at edge n+2, one cycle; TERM=1.
- Stalled counter: BCD held at 23:59:59, three consecutive TICKs → one WRAP only; BCD=00:00:00 then a return to 23:59:59 with TICK → second WRAP.
- 12 h: 11:59:59 with TICK → PM 0→1, no WRAP; 12:59:59 with TICK → WRAP, PM stays 1; MODE_12H→0 → PM=0 two cycles later.
- Invalid digit: BCD=23:5A:59 with TICK → BCD_ERR=1, WRAP=0, TERM=0.
- Reset mid-pulse: RST_N low in the WRAP cycle → WRAP=0 immediately, PM=0, no pulse after release.
- ALARM_EN: ALARM_SET with 07:30:00, ALARM_ON=1, BCD=07:30:00 with TICK → ALARM one cycle; ALARM_ON=0 → no pulse.
